// File: rtl/fifo_bank_skew_if.sv
// Bundles the fill-side write port, the drain command, and the skewed read stream of fifo_bank_skew.
// The master side is the fill controller together with the MAC array; the slave side is the FIFO bank.
interface fifo_bank_skew_if #(
   parameter int NUM_FIFOS  = 9,
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0]           dataByte;
   logic [NUM_FIFOS-1:0]            fifoEnable;
   logic                            start;
   logic [NUM_FIFOS-1:0]            fifoFull;
   logic                            allFull;
   logic [NUM_FIFOS*DATA_WIDTH-1:0] rdData;
   logic [NUM_FIFOS-1:0]            rdValid;
   logic                            busy;
   logic                            done;
   logic                            wrErr;

   modport master (
      output dataByte, fifoEnable, start,
      input  fifoFull, allFull, rdData, rdValid, busy, done, wrErr
   );

   modport slave (
      input  dataByte, fifoEnable, start,
      output fifoFull, allFull, rdData, rdValid, busy, done, wrErr
   );
endinterface

// File: rtl/fifo_bank_skew.sv
// Bank of byte FIFOs filled one-hot or by broadcast, then drained with FIFO i lagging FIFO 0 by i cycles.
// Read data is one cycle behind each pop; there is no backpressure, and dropped writes set the sticky wrErr flag.
module fifo_bank_skew #(
   parameter int NUM_FIFOS  = 9,
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   fifo_bank_skew_if.slave  bus
);
   localparam int PW     = $clog2(DEPTH);
   localparam int CW     = $clog2(DEPTH) + 1;
   localparam int TW     = $clog2(DEPTH + NUM_FIFOS) + 1;
   localparam int T_LAST = DEPTH + NUM_FIFOS - 1;

   typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

   state_t                          state_q, state_d;
   logic [TW-1:0]                   t_q, t_d;
   logic [DATA_WIDTH-1:0]           mem_q [NUM_FIFOS][DEPTH];
   logic [PW-1:0]                   wptr_q [NUM_FIFOS];
   logic [PW-1:0]                   rptr_q [NUM_FIFOS];
   logic [CW-1:0]                   cnt_q [NUM_FIFOS];
   logic [CW-1:0]                   cnt_d [NUM_FIFOS];
   logic [NUM_FIFOS-1:0]            wr_en, pop_en, full_d, full_q, rd_vld_q;
   logic                            all_full_q;
   logic                            wr_err_q, wr_err_d;
   logic [NUM_FIFOS*DATA_WIDTH-1:0] rd_dat_q;

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      case (state_q)
         IDLE: begin
            if (bus.start && all_full_q) begin
               state_d = DRAIN;
               t_d     = '0;
            end
         end
         DRAIN: begin
            if (t_q == TW'(T_LAST)) state_d = DONE;
            else                    t_d     = t_q + 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FIFO i's pop window slides one cycle per index, producing the systolic skew.
   always_comb begin
      wr_en    = '0;
      pop_en   = '0;
      full_d   = '0;
      cnt_d    = cnt_q;
      wr_err_d = wr_err_q;
      for (int i = 0; i < NUM_FIFOS; i++) begin
         if (state_q == IDLE && bus.fifoEnable[i]) begin
            if (cnt_q[i] == CW'(DEPTH)) wr_err_d = 1'b1;
            else                        wr_en[i] = 1'b1;
         end
         if (state_q == DRAIN && t_q >= TW'(i) && t_q <= TW'(i + DEPTH - 1))
            pop_en[i] = 1'b1;
         cnt_d[i]  = cnt_q[i] + CW'(wr_en[i]) - CW'(pop_en[i]);
         full_d[i] = (cnt_d[i] == CW'(DEPTH));
      end
      if (state_q != IDLE && |bus.fifoEnable) wr_err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         t_q        <= '0;
         full_q     <= '0;
         all_full_q <= 1'b0;
         wr_err_q   <= 1'b0;
         rd_vld_q   <= '0;
         rd_dat_q   <= '0;
         for (int i = 0; i < NUM_FIFOS; i++) begin
            wptr_q[i] <= '0;
            rptr_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         state_q    <= state_d;
         t_q        <= t_d;
         full_q     <= full_d;
         all_full_q <= &full_d;
         wr_err_q   <= wr_err_d;
         rd_vld_q   <= pop_en;
         for (int i = 0; i < NUM_FIFOS; i++) begin
            cnt_q[i] <= cnt_d[i];
            if (wr_en[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
            if (pop_en[i]) begin
               rd_dat_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem_q[i][rptr_q[i]];
               rptr_q[i] <= rptr_q[i] + 1'b1;
            end
         end
      end
   end

   // Storage carries no reset; emptiness is tracked entirely by the counts.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FIFOS; i++) begin
         if (wr_en[i]) mem_q[i][wptr_q[i]] <= bus.dataByte;
      end
   end

   assign bus.fifoFull = full_q;
   assign bus.allFull  = all_full_q;
   assign bus.rdData   = rd_dat_q;
   assign bus.rdValid  = rd_vld_q;
   assign bus.busy     = (state_q == DRAIN);
   assign bus.done     = (state_q == DONE);
   assign bus.wrErr    = wr_err_q;
endmodule

// File: tb/tb_fifo_bank_skew.sv
// Directed and randomized bench for fifo_bank_skew, checked against a queue-based reference model.
module tb_fifo_bank_skew;
   localparam int NF    = 9;
   localparam int DEPTH = 8;
   localparam int DW    = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fifo_bank_skew_if #(.NUM_FIFOS(NF), .DATA_WIDTH(DW)) bus ();

   fifo_bank_skew #(.NUM_FIFOS(NF), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference model: one queue per FIFO plus the drain phase.
   logic [DW-1:0]    mq [NF][$];
   int               phase;     // 0 idle, 1 draining, 2 done pulse
   int               tt;
   bit               m_werr;
   logic [NF-1:0]    m_vld;
   logic [NF*DW-1:0] m_dat;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic [NF-1:0] en, input logic [DW-1:0] d,
                             input logic st, input logic rst);
      if (rst) begin
         for (int i = 0; i < NF; i++) mq[i].delete();
         phase = 0; tt = 0; m_werr = 0; m_vld = '0; m_dat = '0;
         return;
      end
      m_vld = '0;
      if (phase == 0) begin
         bit af;
         af = 1;
         for (int i = 0; i < NF; i++) if (mq[i].size() != DEPTH) af = 0;
         for (int i = 0; i < NF; i++) begin
            if (en[i]) begin
               if (mq[i].size() < DEPTH) mq[i].push_back(d);
               else m_werr = 1;
            end
         end
         if (st && af) begin phase = 1; tt = 0; end
      end else begin
         if (en != '0) m_werr = 1;
         if (phase == 1) begin
            for (int i = 0; i < NF; i++) begin
               if (tt >= i && tt < i + DEPTH) begin
                  m_dat[i*DW +: DW] = mq[i].pop_front();
                  m_vld[i] = 1'b1;
               end
            end
            if (tt == DEPTH + NF - 1) phase = 2;
            else tt++;
         end else begin
            phase = 0;
         end
      end
   endtask

   task automatic compare_all();
      logic [NF-1:0] ef;
      for (int i = 0; i < NF; i++) ef[i] = (mq[i].size() == DEPTH);
      chk("fifoFull", bus.fifoFull, ef);
      chk("allFull",  bus.allFull, &ef);
      chk("rdValid",  bus.rdValid, m_vld);
      chk("rdData",   bus.rdData,  m_dat);
      chk("busy",     bus.busy,    phase == 1);
      chk("done",     bus.done,    phase == 2);
      chk("wrErr",    bus.wrErr,   m_werr);
   endtask

   task automatic cyc(input logic [NF-1:0] en, input logic [DW-1:0] d,
                      input logic st, input logic rst);
      bus.fifoEnable = en;
      bus.dataByte   = d;
      bus.start      = st;
      rst_n          = ~rst;
      model_edge(en, d, st, rst);
      @(posedge clk);
      #1;
      compare_all();
      bus.fifoEnable = '0;
      bus.start      = 1'b0;
      rst_n          = 1'b1;
   endtask

   task automatic fill_random();
      for (int n = 0; n < 200; n++) begin
         logic [NF-1:0] nf;
         nf = '0;
         for (int i = 0; i < NF; i++) if (mq[i].size() < DEPTH) nf[i] = 1'b1;
         if (nf == '0) break;
         cyc(NF'($urandom) & nf, DW'($urandom), 1'b0, 1'b0);
      end
      chk("fill_allFull", bus.allFull, 1'b1);
   endtask

   task automatic drain(input bit rand_start);
      int busy_n, done_n, done_at;
      int vn [NF];
      int first [NF];
      busy_n = 0; done_n = 0; done_at = -1;
      for (int i = 0; i < NF; i++) begin vn[i] = 0; first[i] = -1; end
      for (int k = 0; k < 20; k++) begin
         if (k == 0) cyc('0, DW'($urandom), 1'b1, 1'b0);
         else cyc('0, DW'($urandom), rand_start ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
         if (bus.busy) busy_n++;
         if (bus.done) begin done_n++; done_at = k; end
         for (int i = 0; i < NF; i++) begin
            if (bus.rdValid[i]) begin
               vn[i]++;
               if (first[i] < 0) first[i] = k;
            end
         end
      end
      chk("busy_cycles", busy_n, 17);
      chk("done_pulses", done_n, 1);
      chk("done_at", done_at, 17);
      for (int i = 0; i < NF; i++) begin
         chk("valid_count", vn[i], DEPTH);
         chk("valid_first", first[i], i + 1);
      end
      chk("empty_after_drain", bus.fifoFull, '0);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.fifoEnable = '0;
      bus.dataByte   = '0;
      bus.start      = 1'b0;
      phase = 0; tt = 0; m_werr = 0; m_vld = '0; m_dat = '0;

      cyc('0, '0, 1'b0, 1'b1);
      cyc('0, '0, 1'b0, 1'b1);
      chk("reset_busy", bus.busy, 1'b0);
      chk("reset_wrErr", bus.wrErr, 1'b0);

      // Fill/drain with 16*i+j patterns
      for (int j = 0; j < DEPTH; j++)
         for (int i = 0; i < NF; i++)
            cyc(NF'(1 << i), DW'(16 * i + j), 1'b0, 1'b0);
      drain(1'b0);

      // Premature start, then complete the bank
      for (int j = 0; j < DEPTH; j++)
         for (int i = 0; i < NF - 1; i++)
            cyc(NF'(1 << i), DW'($urandom), 1'b0, 1'b0);
      cyc('0, '0, 1'b1, 1'b0);
      chk("premature_busy", bus.busy, 1'b0);
      chk("premature_allFull", bus.allFull, 1'b0);
      for (int j = 0; j < DEPTH; j++) cyc(NF'(1 << (NF - 1)), DW'($urandom), 1'b0, 1'b0);
      chk("late_allFull", bus.allFull, 1'b1);
      drain(1'b1);

      // Overflow on FIFO 3
      for (int j = 0; j < DEPTH; j++) cyc(NF'(1 << 3), DW'(8'h30 + j), 1'b0, 1'b0);
      chk("ovf_full3", bus.fifoFull[3], 1'b1);
      chk("ovf_no_err_yet", bus.wrErr, 1'b0);
      cyc(NF'(1 << 3), 8'hEE, 1'b0, 1'b0);
      chk("ovf_wrErr", bus.wrErr, 1'b1);
      fill_random();
      drain(1'b0);
      cyc('0, '0, 1'b0, 1'b1);

      // Broadcast
      for (int j = 0; j < DEPTH; j++) cyc('1, 8'hA5, 1'b0, 1'b0);
      chk("bcast_allFull", bus.allFull, 1'b1);
      drain(1'b0);

      // Reset in the middle of a drain
      for (int j = 0; j < DEPTH; j++) cyc('1, DW'($urandom), 1'b0, 1'b0);
      cyc('0, '0, 1'b1, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);
      cyc(NF'(1), 8'h11, 1'b0, 1'b0);
      chk("drain_write_err", bus.wrErr, 1'b1);
      cyc('0, '0, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b1);
      chk("rst_mid_rdValid", bus.rdValid, '0);
      chk("rst_mid_busy", bus.busy, 1'b0);
      chk("rst_mid_fifoFull", bus.fifoFull, '0);
      chk("rst_mid_wrErr", bus.wrErr, 1'b0);
      for (int k = 0; k < 4; k++) begin
         cyc('0, '0, 1'b0, 1'b0);
         chk("rst_mid_no_done", bus.done, 1'b0);
      end

      // Back-to-back random passes exercise pointer wrap
      fill_random();
      drain(1'b1);
      fill_random();
      drain(1'b1);
      chk("b2b_wrErr", bus.wrErr, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
